// File: rtl/dataint_ecc_error_logger_if.sv
// Bundle between the SECDED decode stage and the ECC error logger: the decoder
// flags, the access address and the CSR-side controls in, counters/log/irqs out.
interface dataint_ecc_error_logger_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
);

    // Decoder side, aligned to the registered decoder flags.
    logic                  i_valid;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic                  i_error_detected;
    logic                  i_double_error_detected;

    // CSR-side controls.
    logic [CNT_WIDTH-1:0]  i_ce_threshold;
    logic                  i_clear;

    // Status towards the CSR / interrupt fabric.
    logic [CNT_WIDTH-1:0]  o_ce_count;
    logic [CNT_WIDTH-1:0]  o_ue_count;
    logic                  o_log_valid;
    logic                  o_log_type;
    logic [ADDR_WIDTH-1:0] o_log_addr;
    logic                  o_log_overflow;
    logic                  o_irq_ce;
    logic                  o_irq_ue;

    // Driver of the decoder flags and CSR controls.
    modport master (
        output i_valid, i_addr, i_error_detected, i_double_error_detected,
        output i_ce_threshold, i_clear,
        input  o_ce_count, o_ue_count, o_log_valid, o_log_type, o_log_addr,
        input  o_log_overflow, o_irq_ce, o_irq_ue
    );

    // The logger itself.
    modport slave (
        input  i_valid, i_addr, i_error_detected, i_double_error_detected,
        input  i_ce_threshold, i_clear,
        output o_ce_count, o_ue_count, o_log_valid, o_log_type, o_log_addr,
        output o_log_overflow, o_irq_ce, o_irq_ue
    );

endinterface

// File: rtl/dataint_ecc_error_logger.sv
// ECC error logger: classifies registered SECDED decoder flags into correctable
// (CE) and uncorrectable (UE) events, keeps saturating counts, captures the first
// error (a UE displaces a held CE) and raises sticky interrupts. All outputs are
// registered, so an event sampled at edge N is visible after edge N.
module dataint_ecc_error_logger #(
    parameter int ADDR_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    dataint_ecc_error_logger_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD_CE = 2'd1,
        ST_HOLD_UE = 2'd2
    } log_state_e;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    // Registered state.
    log_state_e            state_q;
    logic [CNT_WIDTH-1:0]  ce_cnt_q;
    logic [CNT_WIDTH-1:0]  ue_cnt_q;
    logic                  log_type_q;
    logic [ADDR_WIDTH-1:0] log_addr_q;
    logic                  ovf_q;
    logic                  irq_ce_q;
    logic                  irq_ue_q;

    // Next-state values.
    log_state_e            state_d;
    logic [CNT_WIDTH-1:0]  ce_cnt_d;
    logic [CNT_WIDTH-1:0]  ue_cnt_d;
    logic                  log_type_d;
    logic [ADDR_WIDTH-1:0] log_addr_d;
    logic                  ovf_d;
    logic                  irq_ce_d;
    logic                  irq_ue_d;

    // Event classification. A double-error flag always means UE, even when
    // the single-error flag is also raised by the decoder.
    logic is_ue;
    logic is_ce;

    assign is_ue = bus.i_valid & bus.i_double_error_detected;
    assign is_ce = bus.i_valid & bus.i_error_detected & ~bus.i_double_error_detected;

    // Clear is applied before the same-cycle event, so every next-state
    // computation starts from these "post-clear" views of the state.
    log_state_e            state_base;
    logic [CNT_WIDTH-1:0]  ce_cnt_base;
    logic [CNT_WIDTH-1:0]  ue_cnt_base;
    logic                  log_type_base;
    logic [ADDR_WIDTH-1:0] log_addr_base;
    logic                  ovf_base;
    logic                  irq_ce_base;
    logic                  irq_ue_base;

    assign state_base    = bus.i_clear ? ST_IDLE : state_q;
    assign ce_cnt_base   = bus.i_clear ? '0      : ce_cnt_q;
    assign ue_cnt_base   = bus.i_clear ? '0      : ue_cnt_q;
    assign log_type_base = bus.i_clear ? 1'b0    : log_type_q;
    assign log_addr_base = bus.i_clear ? '0      : log_addr_q;
    assign ovf_base      = bus.i_clear ? 1'b0    : ovf_q;
    assign irq_ce_base   = bus.i_clear ? 1'b0    : irq_ce_q;
    assign irq_ue_base   = bus.i_clear ? 1'b0    : irq_ue_q;

    // Log FSM state register.
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values, independent of block ordering.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Log FSM next state, captured address/type and overflow flag.
    // NOTE: every combinational output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d    = state_base;
        log_type_d = log_type_base;
        log_addr_d = log_addr_base;
        ovf_d      = ovf_base;

        unique case (state_base)
            ST_IDLE: begin
                if (is_ue) begin
                    state_d    = ST_HOLD_UE;
                    log_type_d = 1'b1;
                    log_addr_d = bus.i_addr;
                end else if (is_ce) begin
                    state_d    = ST_HOLD_CE;
                    log_type_d = 1'b0;
                    log_addr_d = bus.i_addr;
                end
            end
            ST_HOLD_CE: begin
                if (is_ue) begin
                    state_d    = ST_HOLD_UE;
                    log_type_d = 1'b1;
                    log_addr_d = bus.i_addr;
                    ovf_d      = 1'b1;
                end else if (is_ce) begin
                    ovf_d      = 1'b1;
                end
            end
            ST_HOLD_UE: begin
                if (is_ue || is_ce) begin
                    ovf_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Saturating counters and sticky interrupt evaluation.
    always_comb begin
        ce_cnt_d = ce_cnt_base;
        ue_cnt_d = ue_cnt_base;

        if (is_ce && (ce_cnt_base != CNT_MAX)) begin
            ce_cnt_d = ce_cnt_base + 1'b1;
        end
        if (is_ue && (ue_cnt_base != CNT_MAX)) begin
            ue_cnt_d = ue_cnt_base + 1'b1;
        end

        // Compared against the next count every cycle, so a threshold lowered
        // below the current count raises the irq even without a new event.
        irq_ce_d = irq_ce_base |
                   ((bus.i_ce_threshold != '0) && (ce_cnt_d >= bus.i_ce_threshold));
        irq_ue_d = irq_ue_base | is_ue;
    end

    // Counter, log and interrupt registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ce_cnt_q   <= '0;
            ue_cnt_q   <= '0;
            log_type_q <= 1'b0;
            log_addr_q <= '0;
            ovf_q      <= 1'b0;
            irq_ce_q   <= 1'b0;
            irq_ue_q   <= 1'b0;
        end else begin
            ce_cnt_q   <= ce_cnt_d;
            ue_cnt_q   <= ue_cnt_d;
            log_type_q <= log_type_d;
            log_addr_q <= log_addr_d;
            ovf_q      <= ovf_d;
            irq_ce_q   <= irq_ce_d;
            irq_ue_q   <= irq_ue_d;
        end
    end

    assign bus.o_ce_count     = ce_cnt_q;
    assign bus.o_ue_count     = ue_cnt_q;
    assign bus.o_log_valid    = (state_q != ST_IDLE);
    assign bus.o_log_type     = log_type_q;
    assign bus.o_log_addr     = log_addr_q;
    assign bus.o_log_overflow = ovf_q;
    assign bus.o_irq_ce       = irq_ce_q;
    assign bus.o_irq_ue       = irq_ue_q;

endmodule

// File: tb/tb_dataint_ecc_error_logger.sv
// Directed bench for the ECC error logger: a 16-bit-counter instance for the
// main behaviour and a 4-bit-counter instance for saturation.
module tb_dataint_ecc_error_logger;

    logic i_clk;
    logic i_rst;
    int   checks;
    int   errors;

    dataint_ecc_error_logger_if #(.ADDR_WIDTH(16), .CNT_WIDTH(16)) bus  ();
    dataint_ecc_error_logger_if #(.ADDR_WIDTH(16), .CNT_WIDTH(4))  bus4 ();

    dataint_ecc_error_logger #(.ADDR_WIDTH(16), .CNT_WIDTH(16)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    dataint_ecc_error_logger #(.ADDR_WIDTH(16), .CNT_WIDTH(4)) dut4 (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus4)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of decoder flags, then sample just after the edge.
    task automatic step(input logic v, input logic [15:0] a, input logic e, input logic d);
        bus.i_valid                 = v;
        bus.i_addr                  = a;
        bus.i_error_detected        = e;
        bus.i_double_error_detected = d;
        @(posedge i_clk);
        #1;
        bus.i_clear = 1'b0;
    endtask

    task automatic step4(input logic v, input logic [15:0] a, input logic e);
        bus4.i_valid          = v;
        bus4.i_addr           = a;
        bus4.i_error_detected = e;
        @(posedge i_clk);
        #1;
        bus4.i_clear = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        i_rst  = 1'b1;
        bus.i_valid = 0; bus.i_addr = '0; bus.i_error_detected = 0;
        bus.i_double_error_detected = 0; bus.i_ce_threshold = '0; bus.i_clear = 0;
        bus4.i_valid = 0; bus4.i_addr = '0; bus4.i_error_detected = 0;
        bus4.i_double_error_detected = 0; bus4.i_ce_threshold = '0; bus4.i_clear = 0;

        // Reset state.
        #12;
        check("rst_ce_count", 32'(bus.o_ce_count), 32'h0);
        check("rst_log_valid", 32'(bus.o_log_valid), 32'h0);
        check("rst_irq_ue", 32'(bus.o_irq_ue), 32'h0);
        i_rst = 1'b0;

        // 1: valid with no flags -> nothing happens.
        for (int i = 0; i < 10; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
        check("t1_ce_count", 32'(bus.o_ce_count), 32'h0);
        check("t1_ue_count", 32'(bus.o_ue_count), 32'h0);
        check("t1_log_valid", 32'(bus.o_log_valid), 32'h0);
        check("t1_irq_ce", 32'(bus.o_irq_ce), 32'h0);
        check("t1_irq_ue", 32'(bus.o_irq_ue), 32'h0);

        // 2: two CEs -> first logged, second overflows.
        step(1'b1, 16'h0010, 1'b1, 1'b0);
        check("t2_ce1_count", 32'(bus.o_ce_count), 32'h1);
        check("t2_ce1_log_valid", 32'(bus.o_log_valid), 32'h1);
        check("t2_ce1_ovf", 32'(bus.o_log_overflow), 32'h0);
        step(1'b1, 16'h0020, 1'b1, 1'b0);
        check("t2_ce_count", 32'(bus.o_ce_count), 32'h2);
        check("t2_log_type", 32'(bus.o_log_type), 32'h0);
        check("t2_log_addr", 32'(bus.o_log_addr), 32'h0010);
        check("t2_ovf", 32'(bus.o_log_overflow), 32'h1);
        check("t2_irq_ce_thr0", 32'(bus.o_irq_ce), 32'h0);

        // 3: clear, then CE, UE, UE (second UE also has the single-error flag).
        bus.i_clear = 1'b1;
        step(1'b0, 16'h0, 1'b0, 1'b0);
        check("t3_clr_ce_count", 32'(bus.o_ce_count), 32'h0);
        check("t3_clr_log_valid", 32'(bus.o_log_valid), 32'h0);
        check("t3_clr_ovf", 32'(bus.o_log_overflow), 32'h0);
        step(1'b1, 16'h0010, 1'b1, 1'b0);
        check("t3_irq_ue_before", 32'(bus.o_irq_ue), 32'h0);
        step(1'b1, 16'h0030, 1'b0, 1'b1);
        check("t3_ue1_count", 32'(bus.o_ue_count), 32'h1);
        check("t3_ue1_irq_ue", 32'(bus.o_irq_ue), 32'h1);
        check("t3_ue1_log_type", 32'(bus.o_log_type), 32'h1);
        check("t3_ue1_log_addr", 32'(bus.o_log_addr), 32'h0030);
        check("t3_ue1_ovf", 32'(bus.o_log_overflow), 32'h1);
        step(1'b1, 16'h0040, 1'b1, 1'b1);
        check("t3_ue2_count", 32'(bus.o_ue_count), 32'h2);
        check("t3_ue2_ce_count", 32'(bus.o_ce_count), 32'h1);
        check("t3_ue2_log_addr", 32'(bus.o_log_addr), 32'h0030);
        check("t3_ue2_log_type", 32'(bus.o_log_type), 32'h1);

        // 4: threshold 3 with three back-to-back CEs.
        bus.i_clear = 1'b1;
        step(1'b0, 16'h0, 1'b0, 1'b0);
        bus.i_ce_threshold = 16'd3;
        step(1'b1, 16'h0100, 1'b1, 1'b0);
        check("t4_irq_ce_n1", 32'(bus.o_irq_ce), 32'h0);
        step(1'b1, 16'h0101, 1'b1, 1'b0);
        check("t4_irq_ce_n2", 32'(bus.o_irq_ce), 32'h0);
        step(1'b1, 16'h0102, 1'b1, 1'b0);
        check("t4_irq_ce_n3", 32'(bus.o_irq_ce), 32'h1);
        check("t4_ce_count", 32'(bus.o_ce_count), 32'h3);
        // Threshold 0 never raises the irq.
        bus.i_clear = 1'b1;
        bus.i_ce_threshold = 16'd0;
        step(1'b0, 16'h0, 1'b0, 1'b0);
        check("t4_clr_irq_ce", 32'(bus.o_irq_ce), 32'h0);
        for (int i = 0; i < 5; i++) step(1'b1, 16'h0200, 1'b1, 1'b0);
        check("t4_thr0_irq_ce", 32'(bus.o_irq_ce), 32'h0);
        check("t4_thr0_ce_count", 32'(bus.o_ce_count), 32'h5);
        // Lowering the threshold below the count raises it without an event.
        bus.i_ce_threshold = 16'd4;
        step(1'b0, 16'h0, 1'b0, 1'b0);
        check("t4_thr_change_irq", 32'(bus.o_irq_ce), 32'h1);
        bus.i_ce_threshold = 16'd0;
        step(1'b0, 16'h0, 1'b0, 1'b0);
        check("t4_irq_sticky", 32'(bus.o_irq_ce), 32'h1);

        // 5: 4-bit counter saturates at 15; clear with same-cycle CE.
        bus4.i_ce_threshold = 4'd15;
        for (int i = 0; i < 15; i++) step4(1'b1, 16'h0300, 1'b1);
        check("t5_count_15", 32'(bus4.o_ce_count), 32'hf);
        step4(1'b1, 16'h0301, 1'b1);
        step4(1'b1, 16'h0302, 1'b1);
        check("t5_count_sat", 32'(bus4.o_ce_count), 32'hf);
        check("t5_sat_ovf", 32'(bus4.o_log_overflow), 32'h1);
        check("t5_sat_irq_ce", 32'(bus4.o_irq_ce), 32'h1);
        check("t5_sat_log_addr", 32'(bus4.o_log_addr), 32'h0300);
        bus4.i_clear = 1'b1;
        step4(1'b1, 16'h0050, 1'b1);
        check("t5_clr_ce_count", 32'(bus4.o_ce_count), 32'h1);
        check("t5_clr_log_valid", 32'(bus4.o_log_valid), 32'h1);
        check("t5_clr_log_type", 32'(bus4.o_log_type), 32'h0);
        check("t5_clr_log_addr", 32'(bus4.o_log_addr), 32'h0050);
        check("t5_clr_ovf", 32'(bus4.o_log_overflow), 32'h0);
        check("t5_clr_irq_ce", 32'(bus4.o_irq_ce), 32'h0);

        // 6: flags with i_valid low are ignored.
        bus.i_clear = 1'b1;
        step(1'b0, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 16'h0077, 1'b1, 1'b1);
        check("t6_novalid_ce", 32'(bus.o_ce_count), 32'h0);
        check("t6_novalid_ue", 32'(bus.o_ue_count), 32'h0);
        check("t6_novalid_log", 32'(bus.o_log_valid), 32'h0);
        check("t6_novalid_irq_ue", 32'(bus.o_irq_ue), 32'h0);
        step(1'b1, 16'h0099, 1'b0, 1'b1);
        check("t6_ue_count", 32'(bus.o_ue_count), 32'h1);
        check("t6_ue_irq", 32'(bus.o_irq_ue), 32'h1);
        // Asynchronous reset between edges.
        bus.i_valid = 1'b1;
        bus.i_error_detected = 1'b1;
        #2;
        i_rst = 1'b1;
        #1;
        check("t6_arst_ue_count", 32'(bus.o_ue_count), 32'h0);
        check("t6_arst_irq_ue", 32'(bus.o_irq_ue), 32'h0);
        check("t6_arst_log_valid", 32'(bus.o_log_valid), 32'h0);
        check("t6_arst_log_addr", 32'(bus.o_log_addr), 32'h0);
        check("t6_arst_ce4", 32'(bus4.o_ce_count), 32'h0);
        // Events during held reset are not counted.
        @(posedge i_clk);
        #1;
        check("t6_rst_edge_ce", 32'(bus.o_ce_count), 32'h0);
        i_rst = 1'b0;
        step(1'b0, 16'h0, 1'b0, 1'b0);
        check("t6_post_rst_ce", 32'(bus.o_ce_count), 32'h0);
        check("t6_post_rst_ovf", 32'(bus.o_log_overflow), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
